pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. Drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources: load-use hazards, taken branches, and a multi-cycle data-memory handshake with timeout. Keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: sequencer state encoding, the hard-wired zero register index, the
// NOP encoding loaded by flushed pipeline registers, and the load-use test.
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // A load targeting r0 never produces a value, so it can never create a hazard.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
    return mem_read && (rd != REG_ZERO) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
//
// Purpose: counts cycles with en high, holding at all-ones.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset, clears count
//   en    in  count this cycle
//   count out current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: drives pipeline register enables, flushes and the MEM/WB bubble from
// load-use hazards, taken branches and the data-memory handshake (with timeout).
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   IFID_RSaddr_i, IFID_RTaddr_i   source registers of the instruction in ID
//   IDEX_MemRead_i, IDEX_RDaddr_i  load flag and destination of the instruction in EX
//   Branch_taken_i                 branch resolved taken in ID
//   Dmem_req_i, Dmem_ack_i         data-memory access request / completion
//   PCWrite_o .. MEMWBBubble_o     combinational pipeline controls
//   MemErr_o                       sticky memory-timeout flag
//   StallCycles_o, FlushCount_o    saturating performance counters
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       IFID_RSaddr_i,
  input  logic [4:0]       IFID_RTaddr_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             Branch_taken_i,
  input  logic             Dmem_req_i,
  input  logic             Dmem_ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXWrite_o,
  output logic             IDEXFlush_o,
  output logic             EXMEMWrite_o,
  output logic             MEMWBBubble_o,
  output logic             MemErr_o,
  output logic [CNT_W-1:0] StallCycles_o,
  output logic [CNT_W-1:0] FlushCount_o
);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lu;
  logic       ms;
  logic       timeout;
  logic       freeze;

  assign lu = load_use_hit(IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RSaddr_i, IFID_RTaddr_i);
  assign ms = Dmem_req_i & ~Dmem_ack_i;

  // wait_cnt holds the number of frozen cycles already spent on the access,
  // including the RUN cycle that raised it, so the forced advance lands on
  // cycle MEM_TIMEOUT counted from the request. An ack always beats the timeout.
  assign timeout = (state == MEM_WAIT) && !Dmem_ack_i && (wait_cnt == 8'(MEM_TIMEOUT - 1));
  assign freeze  = (state == RUN) ? ms : (!Dmem_ack_i && !timeout);

  always_comb begin
    PCWrite_o     = 1'b1;
    IFIDWrite_o   = 1'b1;
    IFIDFlush_o   = 1'b0;
    IDEXWrite_o   = 1'b1;
    IDEXFlush_o   = 1'b0;
    EXMEMWrite_o  = 1'b1;
    MEMWBBubble_o = 1'b0;
    if (freeze) begin
      PCWrite_o     = 1'b0;
      IFIDWrite_o   = 1'b0;
      IDEXWrite_o   = 1'b0;
      EXMEMWrite_o  = 1'b0;
      MEMWBBubble_o = 1'b1;
    end else begin
      // The abandoned access must not retire into MEM/WB.
      if (timeout) MEMWBBubble_o = 1'b1;
      // A branch seen together with a load-use stall is re-resolved next cycle.
      if (lu) begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        IDEXFlush_o = 1'b1;
      end else if (Branch_taken_i) begin
        IFIDFlush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= RUN;
      wait_cnt <= '0;
      MemErr_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ms) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (Dmem_ack_i) begin
            state <= RUN;
          end else if (timeout) begin
            state    <= RUN;
            MemErr_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (!PCWrite_o),
    .count (StallCycles_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (IFIDFlush_o),
    .count (FlushCount_o)
  );

endmodule
